// File: rtl/imul_seq_nbits.sv
// Sequential shift-add multiplier, unsigned or two's-complement, WIDTH-bit operands to a 2*WIDTH-bit product.
// Latency WIDTH+1 cycles from the accepted start to the done pulse; one multiplier bit is retired per RUN cycle.
// No backpressure: iStart is only accepted in IDLE and ignored while oBusy=1; oDone is a one-cycle pulse.
//
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   iStart         start request, sampled only in IDLE together with iSigned, iA, iB
//   iSigned        0 = unsigned operands, 1 = two's-complement operands
//   iA, iB         multiplicand and multiplier
//   oBusy          high while an operation is in RUN or FIX
//   oDone          one-cycle pulse when oResult carries a new product
//   oResult        product, held until the next operation completes
module imul_seq_nbits #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;     // multiplicand magnitude
  logic [2*WIDTH-1:0]   acc;       // {upper partial sum, remaining multiplier bits}
  logic [CNTW-1:0]      cnt;
  logic                 neg;
  logic                 done_q;
  logic [2*WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic                 last_step;

  // Magnitudes: in signed mode a negative operand is negated. -2^(WIDTH-1)
  // negates to itself, which read as unsigned is exactly its magnitude.
  assign a_mag = (iSigned && iA[WIDTH-1]) ? (~iA + ONE_W) : iA;
  assign b_mag = (iSigned && iB[WIDTH-1]) ? (~iB + ONE_W) : iB;

  // Carry-out is kept so the shifted-in MSB is exact.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  assign last_step = (cnt == CNTW'(WIDTH - 1));

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iStart)    state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_FIX;
      S_FIX:                  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iStart) begin
            mcand <= a_mag;
            acc   <= {{WIDTH{1'b0}}, b_mag};
            cnt   <= '0;
            neg   <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          end
        end
        S_RUN: begin
          // {carry, upper, lower} >> 1: the consumed multiplier LSB drops out.
          acc <= {sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          result_q <= neg ? (~acc + ONE_2W) : acc;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oBusy   = (state != S_IDLE);
  assign oDone   = done_q;
  assign oResult = result_q;

endmodule

// File: tb/tb_imul_seq_nbits.sv
// Directed bench for imul_seq_nbits at WIDTH = 8, 2 and 16.
// Inputs are driven and outputs sampled on the falling edge.
// Expected products are hand-computed constants.
module tb_imul_seq_nbits;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  logic        s8 = 0, sg8 = 0, bz8, dn8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] r8;

  logic        s2 = 0, sg2 = 0, bz2, dn2;
  logic [1:0]  a2 = 0, b2 = 0;
  logic [3:0]  r2;

  logic        s16 = 0, sg16 = 0, bz16, dn16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] r16;

  imul_seq_nbits #(.WIDTH(8)) u8 (
    .Clock(Clock), .Reset(Reset), .iStart(s8), .iSigned(sg8), .iA(a8), .iB(b8),
    .oBusy(bz8), .oDone(dn8), .oResult(r8));
  imul_seq_nbits #(.WIDTH(2)) u2 (
    .Clock(Clock), .Reset(Reset), .iStart(s2), .iSigned(sg2), .iA(a2), .iB(b2),
    .oBusy(bz2), .oDone(dn2), .oResult(r2));
  imul_seq_nbits #(.WIDTH(16)) u16 (
    .Clock(Clock), .Reset(Reset), .iStart(s16), .iSigned(sg16), .iA(a16), .iB(b16),
    .oBusy(bz16), .oDone(dn16), .oResult(r16));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic drive(input int sel, input logic st, input logic sg,
                       input logic [15:0] a, input logic [15:0] b);
    case (sel)
      2:       begin s2  = st; sg2  = sg; a2  = a[1:0]; b2  = b[1:0]; end
      16:      begin s16 = st; sg16 = sg; a16 = a;      b16 = b;      end
      default: begin s8  = st; sg8  = sg; a8  = a[7:0]; b8  = b[7:0]; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      2:       return dn2;
      16:      return dn16;
      default: return dn8;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    case (sel)
      2:       return {28'd0, r2};
      16:      return r16;
      default: return {16'd0, r8};
    endcase
  endfunction

  // Single operation on the 8-bit instance; entered and left on a falling edge.
  task automatic run8(input string tag, input logic sg, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    int e, busy_n;
    drive(8, 1'b1, sg, {8'd0, a}, {8'd0, b});
    step();                       // edge 0 accepts the start
    s8 = 1'b0;
    e = 0; busy_n = 0;
    while (e <= 40) begin
      if (bz8) busy_n++;
      if (dn8) break;
      step();
      e++;
    end
    chk({tag, "_lat"}, 64'(e), 64'd9);
    chk({tag, "_res"}, {48'd0, r8}, {48'd0, exp});
    chk({tag, "_busy"}, 64'(busy_n), 64'd9);
    step();
    chk({tag, "_done_drop"}, {63'd0, dn8}, 64'd0);
  endtask

  // iStart held high with two alternating operand sets; every accepted start
  // must complete after lat edges with the right product.
  task automatic b2b(input string tag, input int sel, input int n, input int lat,
                     input logic sg0, input logic [15:0] a0, input logic [15:0] b0, input logic [31:0] x0,
                     input logic sg1, input logic [15:0] a1, input logic [15:0] b1, input logic [31:0] x1);
    int e, nd;
    drive(sel, 1'b1, sg0, a0, b0);
    step();
    for (int i = 0; i < n; i++) begin
      // operand changes during RUN must be ignored; these are for the next op
      if (i % 2 == 0) drive(sel, 1'b1, sg1, a1, b1);
      else            drive(sel, 1'b1, sg0, a0, b0);
      e = 0;
      while (e <= lat + 20) begin
        if (get_done(sel)) break;
        step();
        e++;
      end
      if (i == n - 1) drive(sel, 1'b0, 1'b0, 16'd0, 16'd0);
      chk($sformatf("%s_lat%0d", tag, i), 64'(e), 64'(lat));
      chk($sformatf("%s_res%0d", tag, i), {32'd0, get_res(sel)},
          {32'd0, (i % 2 == 0) ? x0 : x1});
      step();
    end
    nd = 0;
    for (int k = 0; k < lat + 4; k++) begin
      if (get_done(sel)) nd++;
      step();
    end
    chk({tag, "_no_extra_done"}, 64'(nd), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, nd, de;
    logic [15:0] rr;

    // Reset state
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_busy8", {63'd0, bz8}, 64'd0);
    chk("rst_done8", {63'd0, dn8}, 64'd0);
    chk("rst_res8",  {48'd0, r8},  64'd0);
    chk("rst_res2",  {60'd0, r2},  64'd0);
    chk("rst_res16", {32'd0, r16}, 64'd0);
    Reset = 1'b0;
    step();

    // Directed single operations, WIDTH=8
    run8("u13x11",   1'b0, 8'd13,  8'd11,  16'h008F);
    run8("u255x255", 1'b0, 8'hFF,  8'hFF,  16'hFE01);
    run8("u0x200",   1'b0, 8'd0,   8'd200, 16'h0000);
    run8("uFDx5",    1'b0, 8'hFD,  8'd5,   16'h04F1);
    run8("sm3x5",    1'b1, 8'hFD,  8'd5,   16'hFFF1);
    run8("sm128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("sm128x127",  1'b1, 8'h80, 8'h7F, 16'hC080);
    run8("s7xm1",    1'b1, 8'd7,   8'hFF,  16'hFFF9);

    // Start pulse with different operands during RUN cycle 3 is ignored
    drive(8, 1'b1, 1'b0, 16'd13, 16'd11);
    step();
    s8 = 1'b0;
    e = 0;
    repeat (2) begin step(); e++; end
    drive(8, 1'b1, 1'b1, 16'd2, 16'd2);
    step(); e++;
    s8 = 1'b0;
    nd = 0; de = 0; rr = 16'hDEAD;
    while (e < 25) begin
      step(); e++;
      if (dn8) begin
        nd++;
        if (nd == 1) begin de = e; rr = r8; end
      end
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_lat",   64'(de), 64'd9);
    chk("ign_res",   {48'd0, rr}, 64'h008F);

    // Reset in RUN cycle 5 aborts the operation
    drive(8, 1'b1, 1'b0, 16'd100, 16'd3);
    step();
    s8 = 1'b0;
    repeat (4) step();
    Reset = 1'b1;
    step();
    chk("abort_busy", {63'd0, bz8}, 64'd0);
    chk("abort_res",  {48'd0, r8},  64'd0);
    chk("abort_done", {63'd0, dn8}, 64'd0);
    Reset = 1'b0;
    nd = 0;
    repeat (12) begin
      if (dn8) nd++;
      step();
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run8("u6x7", 1'b0, 8'd6, 8'd7, 16'h002A);

    // Back-to-back with iStart held high
    b2b("b2b_w8", 8, 4, 9,
        1'b0, 16'd13, 16'd11, 32'h0000_008F,
        1'b1, 16'h00FD, 16'd5, 32'h0000_FFF1);
    b2b("b2b_w2", 2, 4, 3,
        1'b0, 16'd3, 16'd3, 32'h0000_0009,
        1'b1, 16'd2, 16'd1, 32'h0000_000E);
    b2b("b2b_w16", 16, 4, 17,
        1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001,
        1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
